// File: rtl/instr_encoder_loader.sv
// Program loader: encodes instruction descriptors into MIPS words and
// writes them sequentially into instruction memory with backpressure.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start_i; no descriptors accepted
// LOAD  | ready for a descriptor; encodes and registers it on handshake
// WRITE | holds the write request until memory accepts it
// DONE  | one-cycle done_o pulse, then back to IDLE
module instr_encoder_loader #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     start_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [2:0]               kind_i,
    input  logic [4:0]               rs_i,
    input  logic [4:0]               rt_i,
    input  logic [4:0]               rd_i,
    input  logic [5:0]               funct_i,
    input  logic [15:0]              imm_i,
    input  logic                     last_i,
    output logic                     mem_we_o,
    input  logic                     mem_ready_i,
    output logic [31:0]              mem_addr_o,
    output logic [31:0]              mem_wdata_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [2:0] KIND_R    = 3'd0;
    localparam logic [2:0] KIND_LW   = 3'd1;
    localparam logic [2:0] KIND_SW   = 3'd2;
    localparam logic [2:0] KIND_ADDI = 3'd3;
    localparam logic [2:0] KIND_BEQ  = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           last_q, last_d;
    logic [CW-1:0]  count_q, count_d;
    logic           err_q, err_d;

    logic [31:0]    enc_word;
    logic           enc_legal;

    // Combinational encoder: descriptor fields to a 32-bit MIPS word.
    always_comb begin
        enc_word  = 32'h0000_0000;
        enc_legal = 1'b1;
        case (kind_i)
            KIND_R:    enc_word = {6'b000000, rs_i, rt_i, rd_i, 5'b00000, funct_i};
            KIND_LW:   enc_word = {6'b100011, rs_i, rt_i, imm_i};
            KIND_SW:   enc_word = {6'b101011, rs_i, rt_i, imm_i};
            KIND_ADDI: enc_word = {6'b001000, rs_i, rt_i, imm_i};
            KIND_BEQ:  enc_word = {6'b000100, rs_i, rt_i, imm_i};
            default:   enc_legal = 1'b0;
        endcase
    end

    // State and datapath registers; reset aborts any session in flight.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            addr_q  <= BASE_ADDR;
            wdata_q <= 32'h0000_0000;
            last_q  <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Next-state, datapath updates and Moore outputs.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        last_d     = last_q;
        count_d    = count_q;
        err_d      = err_q;
        in_ready_o = 1'b0;
        mem_we_o   = 1'b0;
        busy_o     = 1'b1;
        done_o     = 1'b0;

        case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    state_d = LOAD;
                    addr_d  = BASE_ADDR;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    // A full session swallows the descriptor and ends, whatever last_i says.
                    if (count_q == CW'(DEPTH)) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (enc_legal) begin
                        wdata_d = enc_word;
                        last_d  = last_i;
                        state_d = WRITE;
                    end else begin
                        err_d = 1'b1;
                        if (last_i) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            WRITE: begin
                mem_we_o = 1'b1;
                if (mem_ready_i) begin
                    addr_d  = addr_q + 32'd4;
                    count_d = count_q + CW'(1);
                    state_d = last_q ? DONE : LOAD;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign err_o       = err_q;
    assign count_o     = count_q;

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Writer-side counterpart of the ID-stage control decoder. It takes instruction descriptions (instruction class plus register, immediate and funct fields) over a valid/ready stream, encodes each into a 32-bit MIPS word, and writes the words sequentially into instruction memory through a write port with backpressure. The testbench and boot logic use it to load programs before the 5-stage pipeline is released. It covers the same instruction subset the decoder accepts: R-type, lw, sw, addi, beq.

Parameters:
DEPTH, 256, instruction memory capacity in words; maximum words written per load session.
BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be word-aligned.

Ports:
clk_i  input  1  clock; all state changes on the rising edge.
rst_n_i  input  1  asynchronous active-low reset.
start_i  input  1  begins a load session; sampled only in IDLE.
in_valid_i  input  1  instruction descriptor valid.
in_ready_o  output  1  descriptor accepted when in_valid_i && in_ready_o.
kind_i  input  3  instruction class: 0 R-type, 1 lw, 2 sw, 3 addi, 4 beq; 5-7 illegal.
rs_i  input  5  rs field.
rt_i  input  5  rt field.
rd_i  input  5  rd field; used by R-type only.
funct_i  input  6  funct field; used by R-type only.
imm_i  input  16  immediate or offset; used by I-type only.
last_i  input  1  marks the final descriptor of the session.
mem_we_o  output  1  instruction-memory write request.
mem_ready_i  input  1  memory accepts the write when mem_we_o && mem_ready_i.
mem_addr_o  output  32  byte address of the write.
mem_wdata_o  output  32  encoded instruction word.
busy_o  output  1  high in every state except IDLE.
done_o  output  1  one-cycle pulse when a session ends.
err_o  output  1  sticky error flag; cleared by start_i or reset.
count_o  output  clog2(DEPTH)+1  words written in the current session.

Behaviour:
- Reset (async, rst_n_i=0): FSM goes to IDLE. All outputs are 0, the address register is BASE_ADDR, count_o is 0. Reset applied mid-session aborts the session immediately: no further writes and no done_o pulse.
- FSM states are IDLE, LOAD, WRITE and DONE.
- IDLE: in_ready_o=0. When start_i=1: go to LOAD, address <= BASE_ADDR, count_o <= 0, err_o <= 0. start_i is ignored in every other state.
- LOAD: in_ready_o=1. On a handshake, the encoded word and last_i are registered.
  - Legal kind: go to WRITE. mem_we_o rises on the next cycle, giving 1-cycle latency from acceptance.
- Encoding, with bit fields listed MSB first:
  - R-type: {6'b000000, rs, rt, rd, 5'b00000, funct}.
  - lw: {6'b100011, rs, rt, imm}.
  - sw: {6'b101011, rs, rt, imm}.
  - addi: {6'b001000, rs, rt, imm}.
  - beq: {6'b000100, rs, rt, imm}.
  - Unused input fields are ignored.
- Illegal kind (5-7): the descriptor is consumed without a write and err_o is set. If last_i=1, go to DONE; otherwise stay in LOAD.
- Capacity: if a descriptor is accepted while count_o==DEPTH, it is not written, err_o is set, and the FSM goes to DONE regardless of last_i.
- WRITE:
  - in_ready_o=0. mem_we_o, mem_addr_o and mem_wdata_o are held stable until mem_ready_i=1.
  - On acceptance: address <= address+4 (32-bit wrap, not otherwise checked) and count_o <= count_o+1. mem_we_o drops in the following cycle unless a new write is pending.
  - Next state is DONE if the registered last flag is set, else LOAD.
- Throughput is 1 word per 2 cycles when mem_ready_i is held high.
- DONE: done_o=1 for exactly one cycle, then go to IDLE. count_o and err_o hold their values until the next start_i.
- mem_addr_o and mem_wdata_o may hold stale values whenever mem_we_o=0.
- in_valid_i outside LOAD has no effect, and no descriptor is lost.

Test Plan:
- Reset, start_i, then addi rs=0 rt=8 imm=5 with last=1 and mem_ready_i=1 -> one write of 32'h20080005 at addr 0; done_o pulses; count_o=1; err_o=0.
- Stream of lw(rs=8,rt=9,imm=4), R-type(rs=8,rt=9,rd=10,funct=0x20), sw(rs=8,rt=9,imm=8), beq(rs=8,rt=9,imm=0xFFFF, last) -> writes in order:
  - 32'h8D090004 at addr 0.
  - 32'h01095020 at addr 4.
  - 32'h AD090008 at addr 8, i.e. 32'hAD090008.
  - 32'h1109FFFF at addr 12.
  - Then count_o=4.
- Hold mem_ready_i=0 for 5 cycles during a write -> mem_we_o, mem_addr_o and mem_wdata_o stay constant and in_ready_o=0; the write completes 1 cycle after mem_ready_i rises.
- kind_i=6 mid-stream (not last) -> no write, err_o=1, following descriptors are written at consecutive addresses; err_o is cleared only by the next start_i.
- DEPTH=4, 5 descriptors -> 4 writes (addrs 0-12); the 5th is accepted but not written, err_o=1, done_o pulses.
- Assert rst_n_i low while in WRITE with mem_ready_i=0 -> all outputs 0 asynchronously; no done_o pulse; start_i restarts at BASE_ADDR.
